tt_um_sid_core: RTL and testbench

//   Three-voice SID-style synthesizer for a TinyTapeout tile (top-level tt_um_sid).
//   Per voice: 24-bit phase accumulator, saw/tri/pulse/noise generators and an 8-bit ADSR envelope.
//   The three voices are summed into an 8-bit PCM value, mix_out, which drives a 1-bit PWM audio pin.

---
 rtl/tt_um_sid_core_if.sv | 18 +
 rtl/tt_um_sid_core.sv | 242 ++++++++++++++++++++++++
 tb/tb_tt_um_sid_core.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_um_sid_core_if.sv
// Tile pin bundle for the SID core: register-write inputs and audio/IO outputs.
//
// Write handshake: the host presents {WE, voice, addr} on ui_in and data on
// uio_in. A write fires on the first clock edge that sees ui_in[7] high after
// it was low on the previous edge; address and data are sampled on that same
// edge. Holding WE high does not repeat the write, and there is no ready or
// acknowledge, so the host simply drops WE before the next write.
interface tt_um_sid_core_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_sid_core.sv
// Three-voice SID-style synthesizer core: per-voice phase accumulator,
// saw/tri/pulse/noise waveforms, 8-bit ADSR envelope, saturating mixer and a
// free-running PWM audio output on uo_out[0].
module tt_um_sid_core #(
    parameter int          CLK_DIV   = 50,
    parameter logic [23:0] LFSR_SEED = 24'h7FFFF8
) (
    input logic             clk,
    input logic             rst_n,
    tt_um_sid_core_if.slave bus
);
    // DECAY also covers the sustain hold: the envelope only moves while it
    // sits above the sustain level, so lowering sustain resumes the decay.
    typedef enum logic [1:0] {ENV_IDLE, ENV_ATTACK, ENV_DECAY, ENV_RELEASE} env_state_t;

    logic        we_prev;
    logic        wr_fire;
    logic [1:0]  wr_voice;
    logic [2:0]  wr_addr;

    logic [15:0] presc;
    logic        tick;

    logic [15:0] freq [3];
    logic [7:0]  pw   [3];
    logic [7:0]  ad   [3];
    logic [7:0]  sr   [3];
    logic [7:0]  ctrl [3];

    logic [23:0] acc      [3];
    logic [23:0] acc_next [3];
    logic [22:0] lfsr     [3];

    env_state_t  env_state      [3];
    env_state_t  env_state_next [3];
    logic [7:0]  env            [3];
    logic [7:0]  env_next       [3];
    logic [12:0] rate_cnt       [3];
    logic [12:0] rate_cnt_next  [3];
    logic        gate_prev      [3];
    logic [7:0]  sus_lvl        [3];

    logic [7:0]  wave [3];
    logic [15:0] prod [3];
    logic [7:0]  vout [3];
    logic [9:0]  mix_sum;
    logic [7:0]  mix_out;
    logic [7:0]  pwm_cnt;

    logic        unused_inputs;

    assign wr_voice = bus.ui_in[4:3];
    assign wr_addr  = bus.ui_in[2:0];
    assign wr_fire  = bus.ui_in[7] & ~we_prev;
    assign tick     = (presc == 16'(CLK_DIV - 1));

    // Last count of an envelope rate period: 8*(r+1)^2 ticks, tripled for decay/release.
    function automatic logic [12:0] rate_last(input logic [3:0] r, input logic slow);
        logic [4:0]  r1;
        logic [9:0]  sq;
        logic [12:0] p;
        r1 = {1'b0, r} + 5'd1;
        sq = 10'(r1) * 10'(r1);
        p  = {sq, 3'b000};
        if (slow) p = p + {p[11:0], 1'b0};
        return p - 13'd1;
    endfunction

    // Register file: WE edge detect and per-voice register writes (voice 3 matches no voice).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_prev <= 1'b0;
            for (int v = 0; v < 3; v++) begin
                freq[v] <= '0;
                pw[v]   <= '0;
                ad[v]   <= '0;
                sr[v]   <= '0;
                ctrl[v] <= '0;
            end
        end else begin
            we_prev <= bus.ui_in[7];
            for (int v = 0; v < 3; v++) begin
                if (wr_fire && wr_voice == 2'(v)) begin
                    case (wr_addr)
                        3'd0:    freq[v][7:0]  <= bus.uio_in;
                        3'd1:    freq[v][15:8] <= bus.uio_in;
                        3'd2:    pw[v]         <= bus.uio_in;
                        3'd4:    ad[v]         <= bus.uio_in;
                        3'd5:    sr[v]         <= bus.uio_in;
                        3'd6:    ctrl[v]       <= bus.uio_in;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Voice-tick prescaler: one-cycle tick every CLK_DIV clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) presc <= '0;
        else        presc <= tick ? '0 : presc + 16'd1;
    end

    // Next accumulator value and sustain level per voice.
    always_comb begin
        for (int v = 0; v < 3; v++) begin
            acc_next[v] = acc[v] + {8'd0, freq[v]};
            sus_lvl[v]  = {sr[v][7:4], sr[v][7:4]};
        end
    end

    // Phase accumulators; noise LFSR clocks on each rising edge of acc[19].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < 3; v++) begin
                acc[v]  <= '0;
                lfsr[v] <= LFSR_SEED[22:0];
            end
        end else if (tick) begin
            for (int v = 0; v < 3; v++) begin
                acc[v] <= acc_next[v];
                if (!acc[v][19] && acc_next[v][19])
                    lfsr[v] <= {lfsr[v][21:0], lfsr[v][22] ^ lfsr[v][17]};
            end
        end
    end

    // Envelope FSM state register and gate history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < 3; v++) begin
                env_state[v] <= ENV_IDLE;
                env[v]       <= '0;
                rate_cnt[v]  <= '0;
                gate_prev[v] <= 1'b0;
            end
        end else begin
            for (int v = 0; v < 3; v++) begin
                env_state[v] <= env_state_next[v];
                env[v]       <= env_next[v];
                rate_cnt[v]  <= rate_cnt_next[v];
                gate_prev[v] <= ctrl[v][0];
            end
        end
    end

    // Envelope FSM next state: gate edges win, otherwise step on voice ticks.
    always_comb begin
        for (int v = 0; v < 3; v++) begin
            env_state_next[v] = env_state[v];
            env_next[v]       = env[v];
            rate_cnt_next[v]  = rate_cnt[v];
            if (ctrl[v][0] && !gate_prev[v]) begin
                env_state_next[v] = ENV_ATTACK;
                rate_cnt_next[v]  = '0;
            end else if (!ctrl[v][0] && gate_prev[v]) begin
                env_state_next[v] = ENV_RELEASE;
                rate_cnt_next[v]  = '0;
            end else if (tick) begin
                case (env_state[v])
                    ENV_ATTACK: begin
                        if (env[v] == 8'hFF) begin
                            env_state_next[v] = ENV_DECAY;
                            rate_cnt_next[v]  = '0;
                        end else if (rate_cnt[v] == rate_last(ad[v][7:4], 1'b0)) begin
                            env_next[v]      = env[v] + 8'd1;
                            rate_cnt_next[v] = '0;
                            if (env[v] == 8'hFE) env_state_next[v] = ENV_DECAY;
                        end else begin
                            rate_cnt_next[v] = rate_cnt[v] + 13'd1;
                        end
                    end
                    ENV_DECAY: begin
                        if (env[v] > sus_lvl[v]) begin
                            if (rate_cnt[v] == rate_last(ad[v][3:0], 1'b1)) begin
                                env_next[v]      = env[v] - 8'd1;
                                rate_cnt_next[v] = '0;
                            end else begin
                                rate_cnt_next[v] = rate_cnt[v] + 13'd1;
                            end
                        end else begin
                            rate_cnt_next[v] = '0;
                        end
                    end
                    ENV_RELEASE: begin
                        if (env[v] == 8'h00) begin
                            env_state_next[v] = ENV_IDLE;
                        end else if (rate_cnt[v] == rate_last(sr[v][3:0], 1'b1)) begin
                            env_next[v]      = env[v] - 8'd1;
                            rate_cnt_next[v] = '0;
                            if (env[v] == 8'h01) env_state_next[v] = ENV_IDLE;
                        end else begin
                            rate_cnt_next[v] = rate_cnt[v] + 13'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Waveform select (AND of enabled generators), envelope scaling and 10-bit mix.
    always_comb begin
        mix_sum = '0;
        for (int v = 0; v < 3; v++) begin
            wave[v] = 8'hFF;
            if (ctrl[v][4])
                wave[v] = wave[v] & (acc[v][23] ? ~acc[v][22:15] : acc[v][22:15]);
            if (ctrl[v][5])
                wave[v] = wave[v] & acc[v][23:16];
            if (ctrl[v][6])
                wave[v] = wave[v] & ((acc[v][23:16] < pw[v]) ? 8'hFF : 8'h00);
            if (ctrl[v][7])
                wave[v] = wave[v] & {lfsr[v][22], lfsr[v][20], lfsr[v][16], lfsr[v][13],
                                     lfsr[v][11], lfsr[v][7],  lfsr[v][4],  lfsr[v][2]};
            if (ctrl[v][7:4] == 4'd0)
                wave[v] = 8'h00;
            prod[v] = 16'(wave[v]) * 16'(env[v]);
            vout[v] = prod[v][15:8];
            mix_sum = mix_sum + 10'(vout[v]);
        end
    end

    // Saturated mix register feeding the PWM comparator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mix_out <= '0;
        else        mix_out <= (mix_sum > 10'd255) ? 8'hFF : mix_sum[7:0];
    end

    // Free-running PWM carrier counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + 8'd1;
    end

    assign bus.uo_out  = {mix_out[7:1], (pwm_cnt < mix_out)};
    assign bus.uio_out = 8'h00;
    assign bus.uio_oe  = 8'h00;

    // Tile enable and reserved address bits carry no function.
    assign unused_inputs = &{1'b0, bus.ena, bus.ui_in[6:5]};
endmodule

// File: tb/tb_tt_um_sid_core.sv
// Bench for tt_um_sid_core: a tick-level reference model of the synth predicts
// mix_out and uo_out for every clock; predictions are queued at each rising
// edge and compared on the following falling edge.
module tb_tt_um_sid_core;
    localparam int CLK_DIV = 2;
    localparam int PH_IDLE = 0;
    localparam int PH_ATT  = 1;
    localparam int PH_DEC  = 2;
    localparam int PH_REL  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    tt_um_sid_core_if bus_if ();

    tt_um_sid_core #(.CLK_DIV(CLK_DIV), .LFSR_SEED(24'h7FFFF8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    always #10 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];

    // reference model state
    int          m_presc;
    int          m_pwm;
    logic        m_we_prev;
    logic [15:0] m_freq [3];
    logic [7:0]  m_pw   [3];
    logic [7:0]  m_ad   [3];
    logic [7:0]  m_sr   [3];
    logic [7:0]  m_ctrl [3];
    logic [23:0] m_acc  [3];
    logic [22:0] m_lfsr [3];
    logic        m_gate_prev [3];
    int          m_env   [3];
    int          m_cnt   [3];
    int          m_phase [3];

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int period(input int r);
        return 8 * (r + 1) * (r + 1);
    endfunction

    function automatic logic [7:0] model_wave(input int v);
        logic [7:0]  a;
        logic [7:0]  w;
        logic [7:0]  t;
        logic [22:0] l;
        if (m_ctrl[v][7:4] == 4'd0) return 8'h00;
        a = m_acc[v][23:16];
        w = 8'hFF;
        if (m_ctrl[v][4]) begin
            t = m_acc[v][22:15];
            if (m_acc[v][23]) t = ~t;
            w = w & t;
        end
        if (m_ctrl[v][5]) w = w & a;
        if (m_ctrl[v][6]) w = w & ((a < m_pw[v]) ? 8'hFF : 8'h00);
        if (m_ctrl[v][7]) begin
            l = m_lfsr[v];
            w = w & {l[22], l[20], l[16], l[13], l[11], l[7], l[4], l[2]};
        end
        return w;
    endfunction

    function automatic logic [7:0] model_mix();
        int total;
        total = 0;
        for (int v = 0; v < 3; v++)
            total += (int'(model_wave(v)) * m_env[v]) / 256;
        return (total > 255) ? 8'hFF : 8'(total);
    endfunction

    task automatic model_reset();
        m_presc   = 0;
        m_pwm     = 0;
        m_we_prev = 1'b0;
        for (int v = 0; v < 3; v++) begin
            m_freq[v] = '0; m_pw[v] = '0; m_ad[v] = '0; m_sr[v] = '0; m_ctrl[v] = '0;
            m_acc[v] = '0;
            m_lfsr[v] = 23'h7FFFF8;
            m_gate_prev[v] = 1'b0;
            m_env[v] = 0; m_cnt[v] = 0; m_phase[v] = PH_IDLE;
        end
    endtask

    // One voice tick of the envelope: count ticks, step when a full period has elapsed.
    task automatic env_tick(input int v);
        int sus;
        sus = int'(m_sr[v][7:4]) * 17;
        case (m_phase[v])
            PH_ATT: begin
                if (m_env[v] == 255) begin
                    m_phase[v] = PH_DEC; m_cnt[v] = 0;
                end else begin
                    m_cnt[v]++;
                    if (m_cnt[v] == period(int'(m_ad[v][7:4]))) begin
                        m_cnt[v] = 0; m_env[v]++;
                        if (m_env[v] == 255) m_phase[v] = PH_DEC;
                    end
                end
            end
            PH_DEC: begin
                if (m_env[v] > sus) begin
                    m_cnt[v]++;
                    if (m_cnt[v] == 3 * period(int'(m_ad[v][3:0]))) begin
                        m_cnt[v] = 0; m_env[v]--;
                    end
                end else begin
                    m_cnt[v] = 0;
                end
            end
            PH_REL: begin
                if (m_env[v] == 0) begin
                    m_phase[v] = PH_IDLE;
                end else begin
                    m_cnt[v]++;
                    if (m_cnt[v] == 3 * period(int'(m_sr[v][3:0]))) begin
                        m_cnt[v] = 0; m_env[v]--;
                        if (m_env[v] == 0) m_phase[v] = PH_IDLE;
                    end
                end
            end
            default: ;
        endcase
    endtask

    // Advance the model by one clock using the inputs present at this edge.
    task automatic model_step();
        logic        tick;
        logic        g;
        logic        fire;
        logic [23:0] nacc;
        int          wv;
        tick    = (m_presc == CLK_DIV - 1);
        m_presc = tick ? 0 : m_presc + 1;
        m_pwm   = (m_pwm + 1) % 256;
        for (int v = 0; v < 3; v++) begin
            g = m_ctrl[v][0];
            if (g && !m_gate_prev[v]) begin
                m_phase[v] = PH_ATT; m_cnt[v] = 0;
            end else if (!g && m_gate_prev[v]) begin
                m_phase[v] = PH_REL; m_cnt[v] = 0;
            end else if (tick) begin
                env_tick(v);
            end
            m_gate_prev[v] = g;
            if (tick) begin
                nacc = m_acc[v] + 24'(m_freq[v]);
                if (!m_acc[v][19] && nacc[19])
                    m_lfsr[v] = {m_lfsr[v][21:0], m_lfsr[v][22] ^ m_lfsr[v][17]};
                m_acc[v] = nacc;
            end
        end
        fire      = bus_if.ui_in[7] && !m_we_prev;
        m_we_prev = bus_if.ui_in[7];
        if (fire && bus_if.ui_in[4:3] != 2'd3) begin
            wv = int'(bus_if.ui_in[4:3]);
            case (bus_if.ui_in[2:0])
                3'd0: m_freq[wv][7:0]  = bus_if.uio_in;
                3'd1: m_freq[wv][15:8] = bus_if.uio_in;
                3'd2: m_pw[wv]         = bus_if.uio_in;
                3'd4: m_ad[wv]         = bus_if.uio_in;
                3'd5: m_sr[wv]         = bus_if.uio_in;
                3'd6: m_ctrl[wv]       = bus_if.uio_in;
                default: ;
            endcase
        end
    endtask

    // Model driver: predict the value the DUT registers at each rising edge.
    initial begin
        logic [7:0] mix_e;
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                model_reset();
                exp_q.delete();
            end else begin
                mix_e = model_mix();
                model_step();
                exp_q.push_back({mix_e[7:1], (m_pwm < int'(mix_e)), mix_e});
            end
        end
    end

    // Scoreboard: compare each prediction on the falling edge after it was queued.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("mix_out", 16'(dut.mix_out), 16'(e[7:0]));
                check_eq("uo_out", 16'(bus_if.uo_out), 16'(e[15:8]));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] v, input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_if.ui_in  = {1'b0, 2'b00, v, a};
        bus_if.uio_in = d;
        @(negedge clk);
        bus_if.ui_in[7] = 1'b1;
        @(negedge clk);
        bus_if.ui_in[7] = 1'b0;
    endtask

    initial begin
        bus_if.ena    = 1'b1;
        bus_if.ui_in  = 8'h00;
        bus_if.uio_in = 8'h00;
        idle(4);
        check_eq("reset_mix", 16'(dut.mix_out), 16'h0000);
        check_eq("reset_uo", 16'(bus_if.uo_out), 16'h0000);
        check_eq("uio_out", 16'(bus_if.uio_out), 16'h0000);
        check_eq("uio_oe", 16'(bus_if.uio_oe), 16'h0000);
        rst_n = 1'b1;
        idle(200);

        // voice 0 saw at freq 0x10C3, instant attack, full sustain
        wr(2'd0, 3'd0, 8'hC3);
        wr(2'd0, 3'd1, 8'h10);
        wr(2'd0, 3'd5, 8'hF0);
        wr(2'd0, 3'd4, 8'h00);
        wr(2'd0, 3'd6, 8'h21);
        idle(9000);
        // pulse 50%, then triangle, then noise (gate stays high)
        wr(2'd0, 3'd2, 8'h80);
        wr(2'd0, 3'd6, 8'h41);
        idle(3000);
        wr(2'd0, 3'd6, 8'h11);
        idle(3000);
        wr(2'd0, 3'd6, 8'h81);
        idle(3000);
        // lower sustain while holding: decay resumes toward 0x88
        wr(2'd0, 3'd5, 8'h80);
        idle(1000);

        // voice 1 tri&saw, voice 2 pulse&saw with slower rates
        wr(2'd1, 3'd0, 8'h00);
        wr(2'd1, 3'd1, 8'h40);
        wr(2'd1, 3'd5, 8'hF0);
        wr(2'd1, 3'd4, 8'h10);
        wr(2'd1, 3'd6, 8'h31);
        wr(2'd2, 3'd0, 8'h34);
        wr(2'd2, 3'd1, 8'h12);
        wr(2'd2, 3'd2, 8'h40);
        wr(2'd2, 3'd5, 8'hA0);
        wr(2'd2, 3'd4, 8'h02);
        wr(2'd2, 3'd6, 8'h61);
        idle(4000);

        // voice field 3 must be ignored
        wr(2'd3, 3'd6, 8'h00);
        wr(2'd3, 3'd1, 8'hFF);
        idle(200);

        // WE held high for 5 clocks with data changing: only the first data commits
        @(negedge clk);
        bus_if.ui_in  = {1'b0, 2'b00, 2'd0, 3'd0};
        bus_if.uio_in = 8'h55;
        @(negedge clk);
        bus_if.ui_in[7] = 1'b1;
        @(negedge clk);
        bus_if.uio_in = 8'hFF;
        bus_if.ui_in  = {1'b1, 2'b00, 2'd0, 3'd1};
        idle(4);
        bus_if.ui_in[7] = 1'b0;
        idle(2000);

        // gate off then on during release: attack restarts from current env
        wr(2'd0, 3'd6, 8'h80);
        idle(500);
        wr(2'd0, 3'd6, 8'h81);
        idle(500);

        // release all voices with release rate 0: everything reaches 0
        wr(2'd0, 3'd6, 8'h20);
        wr(2'd1, 3'd6, 8'h30);
        wr(2'd2, 3'd6, 8'h60);
        idle(12500);
        check_eq("release_zero", 16'(dut.mix_out), 16'h0000);

        // reset asserted mid-tone clears mix_out at once
        wr(2'd0, 3'd6, 8'h21);
        idle(600);
        #3 rst_n = 1'b0;
        #1;
        check_eq("async_reset_mix", 16'(dut.mix_out), 16'h0000);
        check_eq("async_reset_uo", 16'(bus_if.uo_out), 16'h0000);
        idle(3);
        rst_n = 1'b1;
        idle(200);
        check_eq("uio_out_end", 16'(bus_if.uio_out), 16'h0000);
        check_eq("uio_oe_end", 16'(bus_if.uio_oe), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
